// File: rtl/uart_rx_frame_buffer.sv
// 8N1 UART receive front end: oversampled frame decoder feeding a small
// first-word-fall-through byte FIFO drained by a valid/ready consumer.
module uart_rx_frame_buffer #(
  parameter int OVERSAMPLE = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        tick,
  input  logic                        rx,
  output logic [DATA_W-1:0]           data_out,
  output logic                        data_valid,
  input  logic                        data_ready,
  output logic                        frame_err,
  output logic                        overrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic [2:0]                  state_out
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  localparam logic [CNT_W-1:0] MID_TICK  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] LAST_TICK = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_W - 1);
  localparam logic [PTR_W:0]   DEPTH_C   = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    PUSH  = 3'd4,
    BREAK = 3'd5
  } state_t;

  state_t              state;
  logic                rx_meta, rxs;
  logic [CNT_W-1:0]    tcnt;
  logic [BIT_W-1:0]    bitcnt;
  logic [DATA_W-1:0]   shreg;
  logic [DATA_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [PTR_W:0]      count;
  logic                pop, push, fifo_accept;

  assign data_valid  = (count != '0);
  assign pop         = data_valid & data_ready;
  // A full FIFO still takes the byte when the consumer pops in the same clk.
  assign fifo_accept = (count < DEPTH_C) | pop;
  assign push        = (state == PUSH) & fifo_accept;
  assign data_out    = data_valid ? mem[rd_ptr] : '0;
  assign fifo_count  = count;
  assign state_out   = state;

  // Frame decoder: synchronizer, tick/bit counters and flag pulses
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      state     <= IDLE;
      tcnt      <= '0;
      bitcnt    <= '0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rxs       <= rx_meta;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (!rxs) state <= START;
        end
        START: if (tick) begin
          if (tcnt == MID_TICK) begin
            tcnt   <= '0;
            bitcnt <= '0;
            state  <= rxs ? IDLE : DATA;
          end else begin
            tcnt <= tcnt + 1'b1;
          end
        end
        DATA: if (tick) begin
          tcnt <= tcnt + 1'b1;
          if (tcnt == LAST_TICK) begin
            tcnt   <= '0;
            bitcnt <= bitcnt + 1'b1;
            if (bitcnt == LAST_BIT) state <= STOP;
          end
        end
        STOP: if (tick) begin
          tcnt <= tcnt + 1'b1;
          if (tcnt == LAST_TICK) begin
            tcnt <= '0;
            if (rxs) begin
              state <= PUSH;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end
        end
        PUSH: begin
          if (!fifo_accept) overrun <= 1'b1;
          state <= IDLE;
        end
        BREAK: if (rxs) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Byte assembly, LSB arrives first
  always_ff @(posedge clk) begin
    if (state == DATA && tick && tcnt == LAST_TICK)
      shreg <= {rxs, shreg[DATA_W-1:1]};
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= shreg;
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
